// File: rtl/deb_mod_counter.sv
// deb_mod_counter: push-button modulo up/down counter.
// KEY_3 (active-low, asynchronous) is synchronised, debounced on a divided
// sample tick and edge-detected; each accepted press steps a modulo-MODULUS
// counter. CARRY pulses for one cycle on wrap so digits can be cascaded.
// Optional feature: define AUTO_REPEAT_EN to enable hold-to-repeat stepping
// (first repeat after REPEAT_DELAY ticks, then every REPEAT_RATE ticks).
module deb_mod_counter #(
  parameter int WIDTH        = 4,
  parameter int MODULUS      = 10,
  parameter int DEB_STAGES   = 3,
  parameter int SAMPLE_DIV   = 1,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic             PIN_Y2,
  input  logic             SW17,
  input  logic             KEY_3,
  input  logic             UP_DN,
  input  logic             EN,
  output logic [WIDTH-1:0] COUNT,
  output logic             CARRY,
  output logic             PRESSED
);

  localparam int               DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(MODULUS - 1);

  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic [DEB_STAGES-1:0] deb_q, deb_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  pressed_q, pressed_d;
  logic                  pressed_dly_q, pressed_dly_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic                  carry_q, carry_d;
  logic                  tick;
  logic                  step;

  // Synchroniser, sample divider, debounce shift register and press edge detect.
  always_comb begin
    sync1_d       = KEY_3;
    sync2_d       = sync1_q;
    tick          = (div_q == DIV_LAST);
    div_d         = tick ? '0 : div_q + DIV_W'(1);
    deb_d         = tick ? {deb_q[DEB_STAGES-2:0], sync2_q} : deb_q;
    pressed_d     = pressed_q;
    if (deb_q == '0) begin
      pressed_d = 1'b1;
    end else if (&deb_q) begin
      pressed_d = 1'b0;
    end
    pressed_dly_d = pressed_q;
  end

`ifdef AUTO_REPEAT_EN
  localparam int               RPT_MAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int               RPT_W      = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             rpt_first_q, rpt_first_d;
  logic             rpt_fire;

  // Hold timer: counts ticks while pressed, fires after the delay, then at the rate.
  always_comb begin
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
    rpt_fire    = 1'b0;
    if (!pressed_q) begin
      rpt_d       = '0;
      rpt_first_d = 1'b1;
    end else if (tick) begin
      if (rpt_q == (rpt_first_q ? DELAY_LAST : RATE_LAST)) begin
        rpt_fire    = 1'b1;
        rpt_d       = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_d = rpt_q + RPT_W'(1);
      end
    end
  end

  // Hold timer state; cleared by reset and whenever the key is released.
  always_ff @(posedge PIN_Y2 or posedge SW17) begin
    if (SW17) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
    end
  end

  assign step = (pressed_q & ~pressed_dly_q) | rpt_fire;
`else
  logic unused_repeat_params;
  assign unused_repeat_params = ^{REPEAT_DELAY, REPEAT_RATE};

  assign step = pressed_q & ~pressed_dly_q;
`endif

  // Modulo up/down step with one-cycle carry on wrap; disabled steps are dropped.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    if (step && EN) begin
      if (UP_DN) begin
        if (count_q == CNT_LAST) begin
          count_d = '0;
          carry_d = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = CNT_LAST;
          carry_d = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // State registers; reset returns the key path to "released".
  always_ff @(posedge PIN_Y2 or posedge SW17) begin
    if (SW17) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      deb_q         <= '1;
      div_q         <= '0;
      pressed_q     <= 1'b0;
      pressed_dly_q <= 1'b0;
      count_q       <= '0;
      carry_q       <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      deb_q         <= deb_d;
      div_q         <= div_d;
      pressed_q     <= pressed_d;
      pressed_dly_q <= pressed_dly_d;
      count_q       <= count_d;
      carry_q       <= carry_d;
    end
  end

  assign COUNT   = count_q;
  assign CARRY   = carry_q;
  assign PRESSED = pressed_q;

endmodule

// File: tb/tb_deb_mod_counter.sv
// Testbench for deb_mod_counter: scoreboard of expected count steps
// (cycle, value, carry) fed by the stimulus, checked by a negedge monitor.
module tb_deb_mod_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;
  localparam int DEB     = 3;
  localparam int RDELAY  = 50;
  localparam int RRATE   = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             key;
  logic             up_dn;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             carry;
  logic             pressed;

  deb_mod_counter #(
    .WIDTH(WIDTH), .MODULUS(MODULUS), .DEB_STAGES(DEB), .SAMPLE_DIV(1),
    .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)
  ) dut (
    .PIN_Y2(clk), .SW17(rst), .KEY_3(key), .UP_DN(up_dn), .EN(en),
    .COUNT(count), .CARRY(carry), .PRESSED(pressed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int cyc;
    int cnt;
    bit cry;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   model_cnt   = 0;
  int   prev_cnt    = 0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected result of one step landing at edge at_cyc, from the modulo rules.
  task automatic push_at(input int at_cyc, input bit dir, input bit e);
    exp_t x;
    if (e) begin
      if (dir) begin
        x.cnt = (model_cnt + 1) % MODULUS;
        x.cry = (model_cnt == MODULUS - 1);
      end else begin
        x.cnt = (model_cnt + MODULUS - 1) % MODULUS;
        x.cry = (model_cnt == 0);
      end
      x.cyc     = at_cyc;
      model_cnt = x.cnt;
      q.push_back(x);
    end
  endtask

  // A steady fall right after edge c_fall is counted DEB+4 edges later.
  task automatic push_step(input int c_fall, input bit dir, input bit e);
    push_at(c_fall + DEB + 4, dir, e);
  endtask

  task automatic press(input bit dir, input bit e, input int hold, input int rel);
    int c;
    up_dn = dir;
    en    = e;
    c     = cyc;
    key   = 1'b0;
    push_step(c, dir, e);
    tick_n(hold);
    key = 1'b1;
    tick_n(rel);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      tick_n(1);
      n++;
    end
  endtask

  // Monitor: any count change or carry is a DUT step event.
  always @(negedge clk) begin
    if (rst) begin
      prev_cnt = 0;
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        mon_e = q.pop_front();
        check("missing_step_cycle", cyc, mon_e.cyc);
      end
      if (int'(count) != prev_cnt || carry) begin
        if (q.size() == 0) begin
          check("unexpected_step_count", int'(count), prev_cnt);
          check("unexpected_step_carry", int'(carry), 0);
        end else begin
          mon_e = q.pop_front();
          check("step_cycle", cyc, mon_e.cyc);
          check("step_count", int'(count), mon_e.cnt);
          check("step_carry", int'(carry), int'(mon_e.cry));
        end
      end
      if (int'(count) >= MODULUS) check("count_range", int'(count), MODULUS - 1);
      prev_cnt = int'(count);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int seen;
    rst   = 1'b1;
    key   = 1'b1;
    up_dn = 1'b1;
    en    = 1'b1;
    tick_n(3);
    check("reset_count", int'(count), 0);
    check("reset_carry", int'(carry), 0);
    check("reset_pressed", int'(pressed), 0);
    rst = 1'b0;
    tick_n(3);

    // Clean press: PRESSED at edge DEB+3, COUNT at edge DEB+4.
    c   = cyc;
    key = 1'b0;
    push_step(c, 1'b1, 1'b1);
    repeat (DEB + 2) @(posedge clk);
    @(negedge clk);
    check("pressed_before_latency", int'(pressed), 0);
    @(posedge clk);
    @(negedge clk);
    check("pressed_at_latency", int'(pressed), 1);
    tick_n(5);
    key = 1'b1;
    tick_n(DEB + 6);
    drain();
    check("count_after_first", int'(count), 1);

    // Up to 9, then wrap with carry.
    for (int i = 0; i < 8; i++) press(1'b1, 1'b1, 8, 8);
    drain();
    check("count_nine", int'(count), 9);
    press(1'b1, 1'b1, 8, 8);
    drain();
    check("count_wrap_up", int'(count), 0);

    // Down from 0 wraps to 9 with carry, then 8 without.
    press(1'b0, 1'b0 | 1'b1, 8, 8);
    press(1'b0, 1'b1, 8, 8);
    drain();
    check("count_down", int'(count), 8);

    // Short bounce: no PRESSED, no step.
    key = 1'b0; tick_n(2);
    key = 1'b1; tick_n(1);
    key = 1'b0; tick_n(1);
    key = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | int'(pressed);
    end
    check("bounce_pressed", seen, 0);
    tick_n(2);

    // Bounce then steady low: exactly one step.
    up_dn = 1'b1;
    key = 1'b0; tick_n(2);
    key = 1'b1; tick_n(1);
    c   = cyc;
    key = 1'b0;
    push_step(c, 1'b1, 1'b1);
    tick_n(10);
    key = 1'b1;
    tick_n(DEB + 6);
    drain();
    check("count_after_bounce", int'(count), model_cnt);

    // EN low on the press, raised while held: no step.
    en  = 1'b0;
    key = 1'b0;
    tick_n(DEB + 8);
    en = 1'b1;
    tick_n(10);
    key = 1'b1;
    tick_n(DEB + 6);
    check("count_en_low", int'(count), model_cnt);

    // Reset mid-debounce with key held; held key counts once after release.
    key = 1'b0;
    tick_n(2);
    rst = 1'b1;
    tick_n(3);
    check("midreset_count", int'(count), 0);
    check("midreset_pressed", int'(pressed), 0);
    model_cnt = 0;
    c   = cyc;
    rst = 1'b0;
    push_step(c, 1'b1, 1'b1);
    tick_n(12);
    key = 1'b1;
    tick_n(DEB + 6);
    drain();
    check("count_after_reset", int'(count), 1);

    // Randomised presses with optional leading bounce.
    for (int i = 0; i < 40; i++) begin
      bit dir;
      bit e;
      dir   = 1'($urandom_range(0, 1));
      e     = ($urandom_range(0, 4) != 0);
      up_dn = dir;
      en    = e;
      if ($urandom_range(0, 1) == 1) begin
        key = 1'b0; tick_n($urandom_range(1, DEB - 1));
        key = 1'b1; tick_n($urandom_range(1, 3));
      end
      press(dir, e, $urandom_range(DEB + 1, 20), $urandom_range(DEB + 2, 12));
    end
    drain();
    check("count_after_random", int'(count), model_cnt);

`ifdef AUTO_REPEAT_EN
    // Hold ~100 ticks: one press step plus repeats at 50..90 ticks after PRESSED.
    model_cnt = int'(count);
    if (model_cnt != 0) begin
      rst = 1'b1;
      tick_n(3);
      rst = 1'b0;
      model_cnt = 0;
      tick_n(2);
    end
    up_dn = 1'b1;
    en    = 1'b1;
    c     = cyc;
    key   = 1'b0;
    push_step(c, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) push_at(c + DEB + 3 + RDELAY + k * RRATE, 1'b1, 1'b1);
    tick_n(95);
    key = 1'b1;
    tick_n(DEB + 10);
    drain();
    check("count_auto_repeat", int'(count), 6);
`endif

    tick_n(10);
    if (q.size() > 0) check("pending_steps", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/deb_mod_counter.md
Name: deb_mod_counter

Overview:
- Parametrised successor of the board push-button counter.
- Fully synchronous to PIN_Y2: KEY_3 is synchronised, debounced on a divided sample tick and edge-detected. Each accepted press steps a modulo-MODULUS up/down counter.
- Emits a one-cycle CARRY pulse at wrap, so instances can cascade into multi-digit displays.
- Sits between board keys/switches and the 7-segment decoders.

Parameters:
WIDTH, 4, COUNT width; must satisfy 2^WIDTH >= MODULUS
MODULUS, 10, count range 0..MODULUS-1; MODULUS >= 2
DEB_STAGES, 3, consecutive identical samples needed to accept a key level change; >= 2
SAMPLE_DIV, 1, clock cycles per debounce sample tick; 1 = sample every clock
REPEAT_DELAY, 50, ticks held before the first auto-repeat step (AUTO_REPEAT_EN only)
REPEAT_RATE, 10, ticks between subsequent auto-repeat steps (AUTO_REPEAT_EN only)

Ports:
PIN_Y2  in  1  system clock; all state on its rising edge
SW17  in  1  reset, asynchronous, active-high; clears all state
KEY_3  in  1  raw push button, asynchronous, active-low (0 = pressed)
UP_DN  in  1  1 = count up, 0 = count down; sampled on the step cycle
EN  in  1  step enable; steps while EN=0 are discarded, not queued
COUNT  out  WIDTH  current count value
CARRY  out  1  one-cycle pulse on wrap (up: MODULUS-1->0; down: 0->MODULUS-1)
PRESSED  out  1  debounced key level, 1 = held

Behaviour:
- Reset (SW17=1, async): COUNT=0, CARRY=0, PRESSED=0. Synchronisers and debounce shift register are set to released (1). Sample divider = 0. Repeat timer = 0.
- Synchroniser: two flops on KEY_3. Only the second flop feeds the debouncer.
- Tick generation:
  - Divider counts 0..SAMPLE_DIV-1; tick is asserted for the cycle in which the divider equals SAMPLE_DIV-1.
  - With SAMPLE_DIV=1, tick is asserted every cycle.
- Debounce:
  - On each tick, the DEB_STAGES-bit shift register shifts in the synchronised level.
  - PRESSED is registered: it sets when the register is all-0, clears when all-1, and holds otherwise.
- Step pulse: PRESSED & ~PRESSED_d (1 cycle). Release never steps.
- Counter, on step with EN=1:
  - UP_DN=1: COUNT==MODULUS-1 -> COUNT=0 and CARRY=1; otherwise COUNT+1.
  - UP_DN=0: COUNT==0 -> COUNT=MODULUS-1 and CARRY=1; otherwise COUNT-1.
- CARRY is registered and high exactly one cycle, coincident with the new COUNT.
- COUNT never leaves 0..MODULUS-1.
- Latency (SAMPLE_DIV=1): KEY_3 falls and then stays low. Counting the first rising edge after the fall as edge 1:
  - PRESSED rises at edge DEB_STAGES+3.
  - COUNT changes at edge DEB_STAGES+4.
- Bounce: any low glitch shorter than DEB_STAGES consecutive samples produces no step and no PRESSED change.
- EN=0 during a press: the press is lost. Raising EN while the key is still held does not step.
- Reset mid-debounce or while held: all state clears. A key still held after reset release is treated as a new press and produces exactly one step after full latency.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- Defined:
  - While PRESSED=1, a tick counter runs from the press.
  - After REPEAT_DELAY ticks it issues an extra step, then one step every REPEAT_RATE ticks until release.
  - Repeat steps obey EN, UP_DN and wrap/CARRY rules identically.
  - The timer clears on release and on reset.
- Undefined: exactly one step per debounced press; REPEAT_* parameters unused.

Test Plan:
- Reset then clean press/release of KEY_3 (defaults, SAMPLE_DIV=1): COUNT 0->1 exactly at edge 7 after the fall; PRESSED high edge 6; CARRY stays 0.
- Nine presses, UP_DN=1, then a tenth: COUNT reaches 9, the tenth press gives COUNT=0 with CARRY high exactly one cycle.
- From COUNT=0, UP_DN=0, one press: COUNT=9, CARRY pulse. Next press: COUNT=8, no CARRY.
- KEY_3 bounce: 0 for 2 cycles, 1 for 1, 0 for 1, then 1: no step, PRESSED stays 0. Bounce then steady low: exactly one step.
- Press with EN=0, then EN=1 while held: COUNT unchanged. Assert SW17 mid-debounce with key held, release SW17: COUNT=0 then one step to 1.
- AUTO_REPEAT_EN, SAMPLE_DIV=1, REPEAT_DELAY=50, REPEAT_RATE=10, hold 100 ticks:
  - First step at the press.
  - Repeat steps 50, 60, 70, 80 and 90 ticks after PRESSED rises.
  - COUNT=6 at release.
